rab_lookup_arb: RTL and testbench
=================================

# rab_lookup_arb

Shares one RAB translation lookup (a single `slice_top` instance) between `N_PORTS` requesters: round-robin arbitration, sequencing of lookup, result capture and per-port response handshake. Sits between the per-port address front ends and one `slice_top`, and replaces per-port slice replication in area-constrained builds. It also reports misses to the miss-handling register interface and raises the per-port miss, protection and multi-hit interrupt pulses.

## Interface
- `N_PORTS`, 3, number of requesters (2..8)
- `C_AXI_ID_WIDTH`, 8, AXI ID width
- `PORT_ID_WIDTH`, 2, port-index width. Must be at least clog2(N_PORTS) and never less than 1.
- `s_axi_aclk`  in  1  clock
- `s_axi_areset`  in  1  reset, synchronous, active-high
- `req_valid`  in  N_PORTS  request present
- `req_ready`  out  N_PORTS  grant. At most one bit set; transfer when valid&ready.
- `req_addr_min` / `req_addr_max`  in  N_PORTS×32  burst address range
- `req_rw`  in  N_PORTS  0=read, 1=write
- `req_id`  in  N_PORTS×C_AXI_ID_WIDTH  AXI ID
- `lu_addr_min` / `lu_addr_max`  out  32  to slice
- `lu_rw`  out  1  to slice
- `lu_hit`, `lu_prot`, `lu_multi`  in  1  OR-reduced slice results (combinational from `lu_*`)
- `lu_out_addr`  in  32  translated address
- `lu_master_select`  in  1  master select from slice
- `rsp_valid`  out  N_PORTS  response to the granted port. One-hot or zero.
- `rsp_ready`  in  N_PORTS  response consumed
- `rsp_accept`, `rsp_drop`  out  1  decision. Exactly one is set while any `rsp_valid` is set.
- `rsp_out_addr`  out  32  translated address
- `rsp_master_select`  out  1  master select
- `miss_valid`  out  1  one-cycle miss log strobe
- `miss_addr`  out  32  missing address
- `miss_id`  out  PORT_ID_WIDTH+C_AXI_ID_WIDTH  {port, id}
- `miss_full`  in  1  miss FIFO full
- `int_miss`, `int_prot`, `int_multi`  out  N_PORTS  one-cycle interrupt pulses

## Operation
- States: IDLE, LOOKUP, RESP.
- IDLE
  - If any `req_valid` is set, the winner is the first set bit scanning up from `last_grant+1` (mod N_PORTS).
  - `req_ready[winner]`=1 combinationally.
  - On transfer: register addr_min, addr_max, rw, id and the port index. Set `last_grant` to the winner. Go to LOOKUP.
- LOOKUP
  - `lu_*` are driven from the registered request. Outside LOOKUP they hold their last value; they are zero after reset.
  - Register `lu_out_addr` and `lu_master_select`.
  - Classify with priority multi > prot > miss > hit:
    - multi (`lu_multi`): drop, `int_multi[p]` pulse.
    - prot (hit, `lu_prot`): drop, `int_prot[p]` pulse.
    - miss (~`lu_hit`): drop, `int_miss[p]` pulse. `miss_valid` pulses only if ~`miss_full`.
    - hit: accept.
  - Go to RESP.
- RESP
  - `rsp_valid[p]`=1. `rsp_*` stay stable until `rsp_ready[p]`, then go to IDLE.
  - `rsp_ready` from other ports is ignored.
- Miss with `miss_full`=1: the request is still dropped and the interrupt still pulses. No miss is logged.
- `rsp_out_addr` is the registered `lu_out_addr` on accept and 0 on drop.

## Timing
- Request transfer at cycle N, LOOKUP at N+1, `rsp_valid` at N+2.
- With `rsp_ready` tied high: `rsp_valid` lasts 1 cycle, IDLE is at N+3, and peak throughput is one lookup per 3 cycles.
- `int_*` and `miss_valid` pulse for the single cycle N+2, aligned with the first `rsp_valid` cycle.
- No combinational path from `rsp_ready` to `req_ready`. A new grant waits for IDLE.
- Reset values: all outputs 0, state IDLE, `last_grant`=N_PORTS-1 so port 0 wins first.
- Reset mid-operation (any state): the in-flight request is discarded with no response. Next cycle is IDLE with all outputs 0.
- A `req_valid` that drops before grant is legal. A request is only owned by the block after transfer.

## Configuration
- `RAB_LOOKUP_STATS_EN` defined adds outputs `stat_hits`, `stat_misses`, `stat_drops` (each 32-bit, out).
  - Each increments once per classified lookup in LOOKUP and saturates at 0xFFFF_FFFF.
  - Each clears on reset.
- Undefined: these ports still exist, tied to 0, and no counter flops are built.

## Structure
- `rab_arb_pkg`: `state_t` enum {IDLE, LOOKUP, RESP}, `lookup_res_t` struct (accept, out_addr, master_select), `MAX_PORTS`=8.
- Sub-module `rab_rr_arb`: combinational round-robin picker. Inputs: request vector, `last_grant`. Outputs: one-hot grant, index.
- The top holds the FSM, request/result registers, classification and counters.

## Test plan
- Port 0 request 0x1000..0x103F, `lu_hit`=1, `lu_out_addr`=0x8000_1000: `rsp_valid[0]` at N+2, accept, `rsp_out_addr`=0x8000_1000.
- Ports 0, 1 and 2 valid continuously, all hit: grants in order 0, 1, 2, 0, 1. `req_ready` is one-hot, a grant every 3 cycles.
- Port 2, id 0x05, addr 0x4000_0000, `lu_hit`=0, `miss_full`=0: drop, `int_miss`=3'b100 for 1 cycle, `miss_valid`=1, `miss_id`={2'd2, 8'h05}, `miss_addr`=0x4000_0000.
- Same request with `miss_full`=1: drop and `int_miss` pulse, `miss_valid` stays 0. A separate case with `lu_hit`=1, `lu_prot`=1, `lu_multi`=1 gives a drop with only `int_multi` pulsing.
- `rsp_ready[1]` held low for 5 cycles: `rsp_valid[1]` and the data are stable, and no `req_ready` is set while other ports are valid.
- Reset asserted during RESP: the next cycle has all outputs 0; after release, port 0 wins the first grant. With `RAB_LOOKUP_STATS_EN`, 3 hits and 1 miss give `stat_hits`=3, `stat_misses`=1, `stat_drops`=1.

Source files
------------

// File: rtl/rab_arb_pkg.sv
// Shared types and constants for the RAB lookup arbiter.
//   state_t      : arbiter FSM states
//   lookup_res_t : captured lookup result presented on the response side
//   MAX_PORTS    : upper bound on the number of requesters
package rab_arb_pkg;

  localparam int unsigned MAX_PORTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  typedef struct packed {
    logic        accept;
    logic [31:0] out_addr;
    logic        master_select;
  } lookup_res_t;

endpackage

// File: rtl/rab_rr_arb.sv
// Combinational round-robin picker.
// Ports:
//   req        : request vector, one bit per port
//   last_grant : index of the most recently granted port
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted port (zero when no request)
// The search starts at last_grant+1 and wraps modulo N_PORTS.
module rab_rr_arb
  import rab_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= MAX_PORTS; off++) begin
      if (!found && off <= N_PORTS) begin
        idx = 32'(last_grant) + off;
        if (idx >= N_PORTS) begin
          idx = idx - N_PORTS;
        end
        for (int unsigned i = 0; i < N_PORTS; i++) begin
          if (!found && i == idx && req[i]) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            found     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rab_lookup_arb.sv
// Shares a single RAB slice lookup between N_PORTS requesters.
// Round-robin grant in IDLE, one lookup cycle, then a held response to the
// granted port. Misses are logged to the miss interface (unless it is full)
// and per-port miss/prot/multi interrupt pulses are raised with the first
// response cycle.
// Ports:
//   s_axi_aclk, s_axi_areset     : clock, synchronous active-high reset
//   req_*                        : per-port request (valid/ready, range, rw, id)
//   lu_*                         : request to / result from the shared slice
//   rsp_*                        : per-port response handshake and decision
//   miss_*                       : miss log strobe, address, {port,id}, fifo full
//   int_miss/int_prot/int_multi  : per-port one-cycle interrupt pulses
//   stat_hits/misses/drops       : saturating lookup counters
// Optional feature: define RAB_LOOKUP_STATS_EN to build the counters;
// otherwise the stat_* ports are tied to zero.
module rab_lookup_arb
  import rab_arb_pkg::*;
#(
  parameter int unsigned N_PORTS        = 3,
  parameter int unsigned C_AXI_ID_WIDTH = 8,
  parameter int unsigned PORT_ID_WIDTH  = 2
) (
  input  logic                                    s_axi_aclk,
  input  logic                                    s_axi_areset,
  input  logic [N_PORTS-1:0]                      req_valid,
  output logic [N_PORTS-1:0]                      req_ready,
  input  logic [N_PORTS*32-1:0]                   req_addr_min,
  input  logic [N_PORTS*32-1:0]                   req_addr_max,
  input  logic [N_PORTS-1:0]                      req_rw,
  input  logic [N_PORTS*C_AXI_ID_WIDTH-1:0]       req_id,
  output logic [31:0]                             lu_addr_min,
  output logic [31:0]                             lu_addr_max,
  output logic                                    lu_rw,
  input  logic                                    lu_hit,
  input  logic                                    lu_prot,
  input  logic                                    lu_multi,
  input  logic [31:0]                             lu_out_addr,
  input  logic                                    lu_master_select,
  output logic [N_PORTS-1:0]                      rsp_valid,
  input  logic [N_PORTS-1:0]                      rsp_ready,
  output logic                                    rsp_accept,
  output logic                                    rsp_drop,
  output logic [31:0]                             rsp_out_addr,
  output logic                                    rsp_master_select,
  output logic                                    miss_valid,
  output logic [31:0]                             miss_addr,
  output logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] miss_id,
  input  logic                                    miss_full,
  output logic [N_PORTS-1:0]                      int_miss,
  output logic [N_PORTS-1:0]                      int_prot,
  output logic [N_PORTS-1:0]                      int_multi,
  output logic [31:0]                             stat_hits,
  output logic [31:0]                             stat_misses,
  output logic [31:0]                             stat_drops
);

  state_t                      state;
  logic [PORT_ID_WIDTH-1:0]    last_grant;
  logic [PORT_ID_WIDTH-1:0]    port_q;
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  lookup_res_t                 res_q;

  logic [N_PORTS-1:0]          win;
  logic [PORT_ID_WIDTH-1:0]    win_idx;
  logic                        xfer;

  logic [31:0]                 sel_min;
  logic [31:0]                 sel_max;
  logic                        sel_rw;
  logic [C_AXI_ID_WIDTH-1:0]   sel_id;

  logic                        c_multi;
  logic                        c_prot;
  logic                        c_miss;
  logic                        c_hit;

  rab_rr_arb #(
    .N_PORTS (N_PORTS),
    .IDX_W   (PORT_ID_WIDTH)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win),
    .grant_idx  (win_idx)
  );

  // Grant only from IDLE; gated by reset so nothing is offered while held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !s_axi_areset) begin
      req_ready = win;
    end
  end

  assign xfer = |req_ready;

  always_comb begin
    sel_min = '0;
    sel_max = '0;
    sel_rw  = 1'b0;
    sel_id  = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (win[i]) begin
        sel_min = req_addr_min[i*32 +: 32];
        sel_max = req_addr_max[i*32 +: 32];
        sel_rw  = req_rw[i];
        sel_id  = req_id[i*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
      end
    end
  end

  // Priority multi > prot > miss > hit.
  always_comb begin
    c_multi = lu_multi;
    c_prot  = !lu_multi && lu_hit && lu_prot;
    c_miss  = !lu_multi && !lu_hit;
    c_hit   = !lu_multi && lu_hit && !lu_prot;
  end

  assign rsp_accept        = res_q.accept;
  assign rsp_out_addr      = res_q.out_addr;
  assign rsp_master_select = res_q.master_select;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state       <= IDLE;
      last_grant  <= PORT_ID_WIDTH'(N_PORTS - 1);
      port_q      <= '0;
      id_q        <= '0;
      res_q       <= '0;
      lu_addr_min <= '0;
      lu_addr_max <= '0;
      lu_rw       <= 1'b0;
      rsp_valid   <= '0;
      rsp_drop    <= 1'b0;
      miss_valid  <= 1'b0;
      miss_addr   <= '0;
      miss_id     <= '0;
      int_miss    <= '0;
      int_prot    <= '0;
      int_multi   <= '0;
    end else begin
      int_miss   <= '0;
      int_prot   <= '0;
      int_multi  <= '0;
      miss_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            // The lu_* registers double as the captured request.
            lu_addr_min <= sel_min;
            lu_addr_max <= sel_max;
            lu_rw       <= sel_rw;
            id_q        <= sel_id;
            port_q      <= win_idx;
            last_grant  <= win_idx;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          res_q.master_select <= lu_master_select;
          rsp_valid[port_q]   <= 1'b1;
          if (c_hit) begin
            res_q.accept   <= 1'b1;
            res_q.out_addr <= lu_out_addr;
            rsp_drop       <= 1'b0;
          end else begin
            res_q.accept   <= 1'b0;
            res_q.out_addr <= '0;
            rsp_drop       <= 1'b1;
          end
          if (c_multi) begin
            int_multi[port_q] <= 1'b1;
          end else if (c_prot) begin
            int_prot[port_q] <= 1'b1;
          end else if (c_miss) begin
            int_miss[port_q] <= 1'b1;
            if (!miss_full) begin
              miss_valid <= 1'b1;
              miss_addr  <= lu_addr_min;
              miss_id    <= {port_q, id_q};
            end
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready[port_q]) begin
            rsp_valid <= '0;
            res_q     <= '0;
            rsp_drop  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAB_LOOKUP_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;
  logic [31:0] drops_q;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      hits_q   <= '0;
      misses_q <= '0;
      drops_q  <= '0;
    end else if (state == LOOKUP) begin
      if (c_hit && hits_q != '1) begin
        hits_q <= hits_q + 32'd1;
      end
      if (c_miss && misses_q != '1) begin
        misses_q <= misses_q + 32'd1;
      end
      if (!c_hit && drops_q != '1) begin
        drops_q <= drops_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_drops  = drops_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_rab_lookup_arb.sv
module tb_rab_lookup_arb;

  localparam int N  = 3;
  localparam int IW = 8;
  localparam int PW = 2;

  localparam int OC_HIT   = 0;
  localparam int OC_MISS  = 1;
  localparam int OC_PROT  = 2;
  localparam int OC_MULTI = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_rw;
  logic [N*32-1:0] req_addr_min, req_addr_max;
  logic [N*IW-1:0] req_id;
  logic [31:0]     lu_addr_min, lu_addr_max, lu_out_addr;
  logic            lu_rw, lu_hit, lu_prot, lu_multi, lu_master_select;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic            rsp_accept, rsp_drop, rsp_master_select;
  logic [31:0]     rsp_out_addr;
  logic            miss_valid, miss_full;
  logic [31:0]     miss_addr;
  logic [PW+IW-1:0] miss_id;
  logic [N-1:0]    int_miss, int_prot, int_multi;
  logic [31:0]     stat_hits, stat_misses, stat_drops;

  int checks = 0;
  int errors = 0;

  // slice environment: directed values or an address-driven behavioural slice
  logic        auto_slice;
  logic        d_hit, d_prot, d_multi, d_ms;
  logic [31:0] d_out;

  // reference model state
  int          m_busy, m_age, m_last, m_p, m_oc, m_pick;
  int          m_hits, m_misses, m_drops;
  logic        m_mf, m_ms;
  logic [31:0] m_min, m_max, m_out;
  logic        m_rw;
  logic [7:0]  m_id;
  logic [3:0]  m_fl;
  logic [N-1:0] e_ready, e_rv, e_im, e_ip, e_imu;
  logic        e_mv;
  logic [N-1:0] onehot;

  always #5 clk = ~clk;

  rab_lookup_arb #(
    .N_PORTS        (N),
    .C_AXI_ID_WIDTH (IW),
    .PORT_ID_WIDTH  (PW)
  ) dut (
    .s_axi_aclk        (clk),
    .s_axi_areset      (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr_min      (req_addr_min),
    .req_addr_max      (req_addr_max),
    .req_rw            (req_rw),
    .req_id            (req_id),
    .lu_addr_min       (lu_addr_min),
    .lu_addr_max       (lu_addr_max),
    .lu_rw             (lu_rw),
    .lu_hit            (lu_hit),
    .lu_prot           (lu_prot),
    .lu_multi          (lu_multi),
    .lu_out_addr       (lu_out_addr),
    .lu_master_select  (lu_master_select),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_accept        (rsp_accept),
    .rsp_drop          (rsp_drop),
    .rsp_out_addr      (rsp_out_addr),
    .rsp_master_select (rsp_master_select),
    .miss_valid        (miss_valid),
    .miss_addr         (miss_addr),
    .miss_id           (miss_id),
    .miss_full         (miss_full),
    .int_miss          (int_miss),
    .int_prot          (int_prot),
    .int_multi         (int_multi),
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses),
    .stat_drops        (stat_drops)
  );

  // {hit, prot, multi, master_select} of the behavioural slice
  function automatic logic [3:0] slice_fn(input logic [31:0] a);
    logic [2:0] f;
    case (a[2:0])
      3'd0:    f = 3'b000;
      3'd1:    f = 3'b110;
      3'd2:    f = 3'b101;
      3'd3:    f = 3'b001;
      3'd4:    f = 3'b010;
      default: f = 3'b100;
    endcase
    return {f, a[5]};
  endfunction

  function automatic logic [31:0] slice_out(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic int outcome(input logic h, input logic p, input logic m);
    if (m) return OC_MULTI;
    if (h && p) return OC_PROT;
    if (!h) return OC_MISS;
    return OC_HIT;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (v[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  always_comb begin
    if (auto_slice) begin
      {lu_hit, lu_prot, lu_multi, lu_master_select} = slice_fn(lu_addr_min);
      lu_out_addr = slice_out(lu_addr_min);
    end else begin
      lu_hit           = d_hit;
      lu_prot          = d_prot;
      lu_multi         = d_multi;
      lu_master_select = d_ms;
      lu_out_addr      = d_out;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] mn, input logic [31:0] mx,
                         input logic rw, input logic [7:0] id);
    req_addr_min[p*32 +: 32] = mn;
    req_addr_max[p*32 +: 32] = mx;
    req_rw[p]                = rw;
    req_id[p*IW +: IW]       = id;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic txn_quick(input int p, input logic h);
    int w;
    w = 0;
    d_hit = h; d_prot = 1'b0; d_multi = 1'b0; miss_full = 1'b0;
    rsp_ready = '1;
    req_valid = '0;
    req_valid[p] = 1'b1;
    #1;
    while (!req_ready[p] && w < 10) begin
      step();
      w++;
    end
    chk("txn_grant", req_ready[p], 1);
    step();
    req_valid = '0;
    step();
    onehot = '0; onehot[p] = 1'b1;
    chk("txn_rsp_valid", rsp_valid, onehot);
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_rw = '0; req_addr_min = '0; req_addr_max = '0; req_id = '0;
    rsp_ready = '0; miss_full = 1'b0; auto_slice = 1'b0;
    d_hit = 1'b0; d_prot = 1'b0; d_multi = 1'b0; d_ms = 1'b0; d_out = '0;

    // reset state
    step(); step();
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_lu_addr_min", lu_addr_min, 0);
    chk("rst_miss_valid", miss_valid, 0);
    chk("rst_int_miss", int_miss, 0);
    chk("rst_accept_drop", {rsp_accept, rsp_drop}, 0);
    chk("rst_stat_hits", stat_hits, 0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // single hit on port 0
    set_req(0, 32'h1000, 32'h103F, 1'b0, 8'h11);
    d_hit = 1'b1; d_out = 32'h8000_1000; d_ms = 1'b1;
    rsp_ready = '1;
    req_valid = 3'b001;
    #1;
    chk("t1_ready", req_ready, 3'b001);
    step();
    req_valid = '0;
    #1;
    chk("t1_lu_min", lu_addr_min, 32'h1000);
    chk("t1_lu_max", lu_addr_max, 32'h103F);
    chk("t1_lu_rw", lu_rw, 0);
    chk("t1_rsp_early", rsp_valid, 0);
    step();
    chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_accept", {rsp_accept, rsp_drop}, 2'b10);
    chk("t1_out_addr", rsp_out_addr, 32'h8000_1000);
    chk("t1_ms", rsp_master_select, 1);
    chk("t1_ints", {int_miss, int_prot, int_multi, miss_valid}, 0);
    step();
    chk("t1_rsp_done", rsp_valid, 0);

    // three ports continuously valid after reset: 0,1,2,0,1 every 3 cycles
    do_reset();
    set_req(0, 32'h100, 32'h1FF, 1'b0, 8'h01);
    set_req(1, 32'h200, 32'h2FF, 1'b1, 8'h02);
    set_req(2, 32'h300, 32'h3FF, 1'b0, 8'h03);
    d_hit = 1'b1; d_prot = 1'b0; d_multi = 1'b0;
    rsp_ready = '1;
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 15; c++) begin
      onehot = '0;
      onehot[(c / 3) % 3] = 1'b1;
      chk("rr_ready", req_ready, (c % 3 == 0) ? onehot : 3'b000);
      chk("rr_rsp_valid", rsp_valid, (c % 3 == 2) ? onehot : 3'b000);
      step();
    end
    req_valid = '0;

    // miss on port 2, fifo not full
    set_req(2, 32'h4000_0000, 32'h4000_00FF, 1'b1, 8'h05);
    d_hit = 1'b0; d_prot = 1'b0; d_multi = 1'b0; miss_full = 1'b0;
    req_valid = 3'b100;
    #1;
    chk("t3_ready", req_ready, 3'b100);
    step();
    req_valid = '0;
    step();
    chk("t3_rsp_valid", rsp_valid, 3'b100);
    chk("t3_drop", {rsp_accept, rsp_drop}, 2'b01);
    chk("t3_out_zero", rsp_out_addr, 0);
    chk("t3_int_miss", int_miss, 3'b100);
    chk("t3_int_other", {int_prot, int_multi}, 0);
    chk("t3_miss_valid", miss_valid, 1);
    chk("t3_miss_id", miss_id, 10'h205);
    chk("t3_miss_addr", miss_addr, 32'h4000_0000);
    step();
    chk("t3_pulse_end", {int_miss, miss_valid}, 0);

    // same miss with fifo full
    miss_full = 1'b1;
    req_valid = 3'b100;
    #1;
    step();
    req_valid = '0;
    step();
    chk("t4_drop", {rsp_accept, rsp_drop}, 2'b01);
    chk("t4_int_miss", int_miss, 3'b100);
    chk("t4_no_log", miss_valid, 0);
    step();

    // hit+prot+multi: only multi pulses
    d_hit = 1'b1; d_prot = 1'b1; d_multi = 1'b1; miss_full = 1'b0;
    req_valid = 3'b100;
    #1;
    step();
    req_valid = '0;
    step();
    chk("t5_int_multi", int_multi, 3'b100);
    chk("t5_int_others", {int_prot, int_miss, miss_valid}, 0);
    chk("t5_drop", {rsp_accept, rsp_drop}, 2'b01);
    step();

    // port 1 response held off for 5 cycles
    set_req(1, 32'h2000, 32'h20FF, 1'b1, 8'hA1);
    d_hit = 1'b1; d_prot = 1'b0; d_multi = 1'b0; d_out = 32'h1234_5678;
    rsp_ready = '0;
    req_valid = 3'b010;
    #1;
    chk("t6_ready", req_ready, 3'b010);
    step();
    req_valid = 3'b101;
    rsp_ready = 3'b101;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t6_hold_valid", rsp_valid, 3'b010);
      chk("t6_hold_addr", rsp_out_addr, 32'h1234_5678);
      chk("t6_hold_accept", {rsp_accept, rsp_drop}, 2'b10);
      chk("t6_no_grant", req_ready, 0);
      step();
    end
    rsp_ready = 3'b111;
    #1;
    chk("t6_still_valid", rsp_valid, 3'b010);
    step();
    chk("t6_next_grant", req_ready, 3'b100);
    req_valid = '0;
    step();

    // reset while in RESP
    set_req(0, 32'h5000, 32'h50FF, 1'b0, 8'h07);
    rsp_ready = '0;
    req_valid = 3'b001;
    #1;
    step();
    req_valid = 3'b111;
    step();
    chk("t7_in_resp", rsp_valid, 3'b001);
    rst = 1'b1;
    step();
    chk("t7_rsp_valid", rsp_valid, 0);
    chk("t7_req_ready", req_ready, 0);
    chk("t7_lu_min", lu_addr_min, 0);
    chk("t7_rsp_data", {rsp_accept, rsp_drop, rsp_out_addr}, 0);
    chk("t7_ints", {int_miss, int_prot, int_multi, miss_valid}, 0);
    rst = 1'b0;
    #1;
    chk("t7_first_grant", req_ready, 3'b001);
    req_valid = '0;
    step();

    // counters: 3 hits, 1 miss
    txn_quick(0, 1'b1);
    txn_quick(1, 1'b1);
    txn_quick(2, 1'b1);
    txn_quick(0, 1'b0);
`ifdef RAB_LOOKUP_STATS_EN
    chk("stat_hits", stat_hits, 3);
    chk("stat_misses", stat_misses, 1);
    chk("stat_drops", stat_drops, 1);
`else
    chk("stat_tied_zero", {stat_hits, stat_misses, stat_drops}, 0);
`endif

    // randomized traffic against the transaction model
    do_reset();
    auto_slice = 1'b1;
    m_busy = 0; m_age = 0; m_last = N - 1; m_p = 0;
    m_hits = 0; m_misses = 0; m_drops = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      req_valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        set_req(p, $urandom, $urandom, 1'($urandom), 8'($urandom));
      end
      rsp_ready = N'($urandom);
      miss_full = ($urandom_range(0, 3) == 0);
      #1;

      e_ready = '0;
      m_pick  = -1;
      if (m_busy == 0) begin
        m_pick = rr_pick(req_valid, m_last);
        if (m_pick >= 0) e_ready[m_pick] = 1'b1;
      end
      chk("rnd_req_ready", req_ready, e_ready);

      if (m_busy != 0 && m_age == 1) begin
        chk("rnd_lu_min", lu_addr_min, m_min);
        chk("rnd_lu_max", lu_addr_max, m_max);
        chk("rnd_lu_rw", lu_rw, m_rw);
      end

      e_rv = '0; e_im = '0; e_ip = '0; e_imu = '0; e_mv = 1'b0;
      if (m_busy != 0 && m_age >= 2) e_rv[m_p] = 1'b1;
      if (m_busy != 0 && m_age == 2) begin
        if (m_oc == OC_MULTI) e_imu[m_p] = 1'b1;
        if (m_oc == OC_PROT)  e_ip[m_p]  = 1'b1;
        if (m_oc == OC_MISS) begin
          e_im[m_p] = 1'b1;
          e_mv = !m_mf;
        end
      end
      chk("rnd_rsp_valid", rsp_valid, e_rv);
      chk("rnd_int_miss", int_miss, e_im);
      chk("rnd_int_prot", int_prot, e_ip);
      chk("rnd_int_multi", int_multi, e_imu);
      chk("rnd_miss_valid", miss_valid, e_mv);
      if (m_busy != 0 && m_age >= 2) begin
        chk("rnd_decision", {rsp_accept, rsp_drop}, (m_oc == OC_HIT) ? 2'b10 : 2'b01);
        chk("rnd_out_addr", rsp_out_addr, (m_oc == OC_HIT) ? m_out : 32'h0);
        if (m_oc == OC_HIT) chk("rnd_ms", rsp_master_select, m_ms);
      end
      if (e_mv) begin
        chk("rnd_miss_addr", miss_addr, m_min);
        chk("rnd_miss_id", miss_id, {PW'(m_p), m_id});
      end

      if (m_busy == 0) begin
        if (m_pick >= 0) begin
          m_busy = 1; m_age = 1; m_p = m_pick; m_last = m_pick;
          m_min = req_addr_min[m_pick*32 +: 32];
          m_max = req_addr_max[m_pick*32 +: 32];
          m_rw  = req_rw[m_pick];
          m_id  = req_id[m_pick*IW +: IW];
        end
      end else if (m_age == 1) begin
        m_mf  = miss_full;
        m_fl  = slice_fn(m_min);
        m_ms  = m_fl[0];
        m_out = slice_out(m_min);
        m_oc  = outcome(m_fl[3], m_fl[2], m_fl[1]);
        if (m_oc == OC_HIT) m_hits++;
        else m_drops++;
        if (m_oc == OC_MISS) m_misses++;
        m_age = 2;
      end else begin
        if (rsp_ready[m_p]) m_busy = 0;
        else m_age++;
      end
      step();
    end
`ifdef RAB_LOOKUP_STATS_EN
    chk("rnd_stat_hits", stat_hits, m_hits);
    chk("rnd_stat_misses", stat_misses, m_misses);
    chk("rnd_stat_drops", stat_drops, m_drops);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
